// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor
// Brief    : Bit-serial a - b - bin, LSB first, one full-subtractor cell per cycle.
//            Optional macro SERIAL_SUB_SATURATE_EN floors a borrowing result to zero.
// Revision : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] difference,
    output logic             borrow_out
);

    localparam int c_cnt_w = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_sr_q, a_sr_d;
    logic [WIDTH-1:0]   b_sr_q, b_sr_d;
    logic [WIDTH-1:0]   res_sr_q, res_sr_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic [c_cnt_w-1:0] count_q, count_d;
    logic               borrow_q, borrow_d;
    logic               bout_q, bout_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               w_diff_bit;
    logic               w_borrow_nxt;
    logic [WIDTH-1:0]   w_res_nxt;

    assign w_diff_bit   = a_sr_q[0] ^ b_sr_q[0] ^ borrow_q;
    assign w_borrow_nxt = (~a_sr_q[0] & b_sr_q[0]) | (~(a_sr_q[0] ^ b_sr_q[0]) & borrow_q);
    assign w_res_nxt    = {w_diff_bit, res_sr_q[WIDTH-1:1]};

    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        res_sr_d = res_sr_q;
        diff_d   = diff_q;
        count_d  = count_q;
        borrow_d = borrow_q;
        bout_d   = bout_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_sr_d   = a;
                    b_sr_d   = b;
                    borrow_d = bin;
                    res_sr_d = '0;
                    count_d  = '0;
                    busy_d   = 1'b1;
                    state_d  = S_SHIFT;
                end
            end
            S_SHIFT: begin
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                res_sr_d = w_res_nxt;
                borrow_d = w_borrow_nxt;
                count_d  = count_q + c_cnt_w'(1);
                if (count_q == c_last_cnt) begin
                    // Last bit: publish result in the same edge the done pulse rises.
`ifdef SERIAL_SUB_SATURATE_EN
                    diff_d = w_borrow_nxt ? '0 : w_res_nxt;
`else
                    diff_d = w_res_nxt;
`endif
                    bout_d  = w_borrow_nxt;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    busy_d = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            res_sr_q <= '0;
            diff_q   <= '0;
            count_q  <= '0;
            borrow_q <= 1'b0;
            bout_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            res_sr_q <= res_sr_d;
            diff_q   <= diff_d;
            count_q  <= count_d;
            borrow_q <= borrow_d;
            bout_q   <= bout_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign difference = diff_q;
    assign borrow_out = bout_q;

endmodule
`default_nettype wire
